// File: rtl/bit_serial_sub.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first, one full-subtractor step per clock.
// Optional signed-overflow output ovf when the macro SUB_OVF_EN is defined.
module bit_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Full-subtractor cell; returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic br);
    logic d;
    logic bo;
    d  = ai ^ bi ^ br;
    bo = (~ai & bi) | (~(ai ^ bi) & br);
    return {bo, d};
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic             d_s;
  logic             bo_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             br_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  assign {bo_s, d_s} = full_sub(a_r[0], b_r[0], br_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = S_SHIFT;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s       = 1'b1;
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_SHIFT;
        end
      end
      S_DONE: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. The minuend register doubles as the result
  // register: each difference bit enters at the MSB as the consumed LSB leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      if (load_s) begin
        a_r   <= a;
        b_r   <= b;
        br_r  <= bin;
        cnt_r <= '0;
      end else if (step_s) begin
        a_r   <= {d_s, a_r[WIDTH-1:1]};
        b_r   <= b_r >> 1;
        br_r  <= bo_s;
        cnt_r <= cnt_r + CNT_W'(1);
        if (last_s) begin
          diff_r <= {d_s, a_r[WIDTH-1:1]};
          bout_r <= bo_s;
        end
      end
      busy_r <= (next_state_s != S_IDLE);
      done_r <= (next_state_s == S_DONE);
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_r;

  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (step_s && last_s) begin
      ovf_r <= br_r ^ bo_s;
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule
